// File: rtl/math_expression_iter.sv
// Multi-cycle evaluator of N = (a - b)(1 + 3c) - 4d using a shift-add multiplier.
// Returns floor(N/2), N[0] and a signed-W overflow flag through a start/busy/valid handshake.
module math_expression_iter #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic                busy,
    output logic                valid,
    output logic signed [W-1:0] q,
    output logic                rmd,
    output logic                ovf
);

    localparam int PW = 2*W + 4;
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

    state_t r_state, w_next;

    logic signed [W:0]   w_diff;
    logic [W:0]          w_diff_mag;
    logic signed [W+2:0] w_c_ext;
    logic signed [W+2:0] w_m;
    logic [W+2:0]        w_m_neg;
    logic [W+1:0]        w_m_mag;
    logic                w_sign;

    logic [PW-1:0]       r_mcand;
    logic [W+1:0]        r_mplier;
    logic                r_sign;
    logic signed [W-1:0] r_d;
    logic [PW-1:0]       r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_valid;
    logic signed [W-1:0] r_q;
    logic                r_rmd;
    logic                r_ovf;

    logic [PW-1:0]        w_sacc;
    logic signed [PW-1:0] w_n;
    logic signed [PW-1:0] w_half;
    logic                 w_ovf;

    // Operand preparation: exact widths so neither the difference nor 1+3c can wrap.
    assign w_diff     = {a[W-1], a} - {b[W-1], b};
    assign w_diff_mag = w_diff[W] ? -w_diff : w_diff;
    assign w_c_ext    = {{3{c[W-1]}}, c};
    assign w_m        = (w_c_ext <<< 1) + w_c_ext + {{(W+2){1'b0}}, 1'b1};
    assign w_m_neg    = -w_m;
    assign w_m_mag    = w_m[W+2] ? w_m_neg[W+1:0] : w_m[W+1:0];
    assign w_sign     = w_diff[W] ^ w_m[W+2];

    assign w_sacc = r_sign ? -r_acc : r_acc;
    assign w_n    = $signed(w_sacc) - $signed({{(W+2){r_d[W-1]}}, r_d, 2'b00});
    assign w_half = w_n >>> 1;
    // floor(N/2) fits in signed W only if everything above bit W-2 is a pure sign extension.
    assign w_ovf  = !((&w_half[PW-1:W-1]) || !(|w_half[PW-1:W-1]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MUL;
            S_MUL:   if (r_cnt == CW'(W + 1)) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_d      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_q      <= '0;
            r_rmd    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{(W+3){1'b0}}, w_diff_mag};
                        r_mplier <= w_m_mag;
                        r_sign   <= w_sign;
                        r_d      <= d;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    r_q     <= w_n[W:1];
                    r_rmd   <= w_n[0];
                    r_ovf   <= w_ovf;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign valid = r_valid;
    assign q     = r_q;
    assign rmd   = r_rmd;
    assign ovf   = r_ovf;

endmodule
